// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS datapath: ALU operation
// encodings and the default reset vector.
package mips_pkg;

  localparam int ALUCONT_W = 4;

  localparam logic [ALUCONT_W-1:0] ALU_AND   = 4'b0000;
  localparam logic [ALUCONT_W-1:0] ALU_OR    = 4'b0001;
  localparam logic [ALUCONT_W-1:0] ALU_ADD   = 4'b0010;
  localparam logic [ALUCONT_W-1:0] ALU_SUB   = 4'b0110;
  localparam logic [ALUCONT_W-1:0] ALU_SLT   = 4'b0111;
  localparam logic [ALUCONT_W-1:0] ALU_SLTU  = 4'b1111;
  localparam logic [ALUCONT_W-1:0] ALU_PASSA = 4'b1000;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage : mips_pkg

// File: rtl/mips_alu_pc_unit_if.sv
// Datapath-facing bundle of the ALU/PC unit. The datapath is the master:
// it supplies the next PC and ALU operands and consumes pc, pcplus4,
// the ALU result and the zero flag.
interface mips_alu_pc_unit_if
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic [WIDTH-1:0]     pcnext;
  logic [WIDTH-1:0]     pc;
  logic [WIDTH-1:0]     pcplus4;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [ALUCONT_W-1:0] alucont;
  logic [WIDTH-1:0]     result;
  logic                 zero;

  modport master (
    output pcnext, a, b, alucont,
    input  pc, pcplus4, result, zero
  );

  modport slave (
    input  pcnext, a, b, alucont,
    output pc, pcplus4, result, zero
  );

endinterface : mips_alu_pc_unit_if

// File: rtl/mips_alu_core.sv
// Combinational 32-bit MIPS ALU with zero flag. SUB, SLT and SLTU share one
// a + ~b + 1 subtractor; SLT takes the overflow-corrected sign of the
// difference, SLTU takes the borrow out of it.
module mips_alu_core
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [ALUCONT_W-1:0] alucont,
  output logic [WIDTH-1:0]     result,
  output logic                 zero
);

  logic [WIDTH:0]   sub_ext;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             sub_ovf;
  logic             lt_signed;

  // Shared subtractor and the comparison flags derived from it.
  always_comb begin
    sub_ext   = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    diff      = sub_ext[WIDTH-1:0];
    borrow    = ~sub_ext[WIDTH];
    // Overflow when operand signs differ and the difference's sign differs from a.
    sub_ovf   = (a[WIDTH-1] ^ b[WIDTH-1]) & (diff[WIDTH-1] ^ a[WIDTH-1]);
    lt_signed = diff[WIDTH-1] ^ sub_ovf;
  end

  // Operation select; unlisted codes yield zero so the zero flag reads 1.
  always_comb begin
    // NOTE: default assigned first so no path through the case leaves result unassigned (no latch).
    result = '0;
    case (alucont)
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = diff;
      ALU_SLT:   result = {{(WIDTH-1){1'b0}}, lt_signed};
      ALU_SLTU:  result = {{(WIDTH-1){1'b0}}, borrow};
      ALU_PASSA: result = a;
      default:   result = '0;
    endcase
  end

  assign zero = ~|result;

endmodule : mips_alu_core

// File: rtl/mips_alu_pc_unit.sv
// Arithmetic and program-counter leaf logic of the single-cycle MIPS
// datapath: PC register with synchronous reset, PC incrementer and the ALU.
module mips_alu_pc_unit
  import mips_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT),
  parameter logic [WIDTH-1:0] PC_INCR  = WIDTH'(4)
) (
  input  logic                      clk,
  input  logic                      reset,
  mips_alu_pc_unit_if.slave         bus
);

  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc_q;

  // Next PC: reset vector while reset is high, otherwise the datapath's pcnext.
  always_comb begin
    pc_d = bus.pcnext;
    if (reset) pc_d = RESET_PC;
  end

  // PC register; reset is folded into pc_d, so it only acts on a rising edge.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    pc_q <= pc_d;
  end

  assign bus.pc      = pc_q;
  assign bus.pcplus4 = pc_q + PC_INCR;

  mips_alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .a       (bus.a),
    .b       (bus.b),
    .alucont (bus.alucont),
    .result  (bus.result),
    .zero    (bus.zero)
  );

endmodule : mips_alu_pc_unit

// File: tb/tb_mips_alu_pc_unit.sv
// Self-checking bench for mips_alu_pc_unit: table-driven ALU vectors, random
// ALU operations against a behavioural model, and hand-written PC/reset
// sequences. Expected values go into a scoreboard queue when stimulus is
// driven and are popped when the outputs are sampled.
module tb_mips_alu_pc_unit;
  import mips_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] exp_res;
    logic        exp_zero;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  sb_t  sb_q[$];
  vec_t vecs[14];

  mips_alu_pc_unit_if #(.WIDTH(32)) bus ();

  mips_alu_pc_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic sb_push(input string name, input logic [31:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop_check(input logic [31:0] act);
    sb_t e;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_empty: got %h want <queued entry>", act);
    end else begin
      e = sb_q.pop_front();
      check(e.name, act, e.exp);
    end
  endtask

  // Drive one ALU operation away from the clock edge and compare result/zero.
  task automatic alu_apply(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op, input logic [31:0] exp_res, input logic exp_zero);
    @(negedge clk);
    bus.a       = a;
    bus.b       = b;
    bus.alucont = op;
    sb_push({name, "_result"}, exp_res);
    sb_push({name, "_zero"}, {31'b0, exp_zero});
    #1;
    sb_pop_check(bus.result);
    sb_pop_check({31'b0, bus.zero});
  endtask

  // One full PC cycle: drive at negedge, check pc/pcplus4 just after the rising edge.
  task automatic pc_step(input string name, input logic rst_v, input logic [31:0] next_v,
                         input logic [31:0] exp_pc);
    logic [31:0] exp_p4;
    exp_p4 = exp_pc + 32'd4;
    @(negedge clk);
    reset      = rst_v;
    bus.pcnext = next_v;
    sb_push({name, "_pc"}, exp_pc);
    sb_push({name, "_pcplus4"}, exp_p4);
    @(posedge clk);
    #1;
    sb_pop_check(bus.pc);
    sb_pop_check(bus.pcplus4);
  endtask

  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
    case (op)
      ALU_AND:   return a & b;
      ALU_OR:    return a | b;
      ALU_ADD:   return a + b;
      ALU_SUB:   return a - b;
      ALU_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU:  return (a < b) ? 32'd1 : 32'd0;
      ALU_PASSA: return a;
      default:   return 32'd0;
    endcase
  endfunction

  initial begin
    logic [3:0]  ops[6];
    logic [31:0] ra;
    logic [31:0] rb;
    logic [3:0]  rop;
    logic [31:0] rres;

    total = 0;
    bad   = 0;
    reset       = 1'b1;
    bus.pcnext  = 32'h0000_1234;
    bus.a       = '0;
    bus.b       = '0;
    bus.alucont = ALU_AND;

    vecs[0]  = '{"add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, ALU_ADD,   32'h8000_0000, 1'b0};
    vecs[1]  = '{"sub_eq",    32'h0000_0005, 32'h0000_0005, ALU_SUB,   32'h0000_0000, 1'b1};
    vecs[2]  = '{"slt_neg",   32'hFFFF_FFFF, 32'h0000_0001, ALU_SLT,   32'h0000_0001, 1'b0};
    vecs[3]  = '{"sltu_big",  32'hFFFF_FFFF, 32'h0000_0001, ALU_SLTU,  32'h0000_0000, 1'b1};
    vecs[4]  = '{"slt_min",   32'h8000_0000, 32'h7FFF_FFFF, ALU_SLT,   32'h0000_0001, 1'b0};
    vecs[5]  = '{"and",       32'h0000_F0F0, 32'h0000_0FF0, ALU_AND,   32'h0000_00F0, 1'b0};
    vecs[6]  = '{"or",        32'h0000_F0F0, 32'h0000_0FF0, ALU_OR,    32'h0000_FFF0, 1'b0};
    vecs[7]  = '{"passa",     32'h0040_0020, 32'h0000_DEAD, ALU_PASSA, 32'h0040_0020, 1'b0};
    vecs[8]  = '{"undef_op",  32'h1234_5678, 32'h8765_4321, 4'b0101,   32'h0000_0000, 1'b1};
    vecs[9]  = '{"slt_max",   32'h7FFF_FFFF, 32'h8000_0000, ALU_SLT,   32'h0000_0000, 1'b1};
    vecs[10] = '{"sltu_small",32'h0000_0001, 32'hFFFF_FFFF, ALU_SLTU,  32'h0000_0001, 1'b0};
    vecs[11] = '{"sub_wrap",  32'h0000_0000, 32'h0000_0001, ALU_SUB,   32'hFFFF_FFFF, 1'b0};
    vecs[12] = '{"add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, ALU_ADD,   32'h0000_0000, 1'b1};
    vecs[13] = '{"undef_op3", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0011,   32'h0000_0000, 1'b1};

    // PC reset and normal load.
    pc_step("rst",  1'b1, 32'h0000_1234, 32'h0000_0000);
    pc_step("load", 1'b0, 32'h0000_0040, 32'h0000_0040);

    // Reset raised mid-cycle must not touch pc before the next edge.
    @(negedge clk);
    reset      = 1'b1;
    bus.pcnext = 32'h0000_0099;
    sb_push("midrst_hold_pc", 32'h0000_0040);
    #1;
    sb_pop_check(bus.pc);
    sb_push("midrst_edge_pc", 32'h0000_0000);
    @(posedge clk);
    #1;
    sb_pop_check(bus.pc);

    // Incrementer wrap and a few ordinary loads.
    pc_step("wrap",  1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    pc_step("seq1",  1'b0, 32'h0040_0000, 32'h0040_0000);
    pc_step("seq2",  1'b0, 32'hA5A5_5A58, 32'hA5A5_5A58);
    pc_step("rst2",  1'b1, 32'h0000_0010, 32'h0000_0000);

    // Directed ALU table.
    for (int i = 0; i < 14; i++) begin
      alu_apply(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp_res, vecs[i].exp_zero);
    end

    // Random ALU operations against the behavioural model.
    ops = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU};
    for (int i = 0; i < 40; i++) begin
      ra   = $urandom;
      rb   = (i % 8 == 0) ? ra : $urandom;
      rop  = ops[$urandom_range(0, 5)];
      rres = alu_model(ra, rb, rop);
      alu_apply($sformatf("rand%0d_op%0h", i, rop), ra, rb, rop, rres, (rres == 32'd0));
    end

    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL sb_drain: got %0d entries want 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mips_alu_pc_unit
